// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Round-robin arbiter that owns the load/clear/data inputs of a single
//   WIDTH-bit register shared by NUM_REQ requesters. Each transaction runs
//   IDLE -> WRITE -> ACK -> IDLE: requests are sampled in IDLE, the register
//   strobe is driven for the single WRITE cycle, and the winner receives a
//   one-cycle ack in ACK. sys_clear beats every requester and performs an
//   ownerless clear (no gnt, no ack, pointer untouched).
//
// Build option:
//   REG_ARB_FIXED_PRIORITY_EN - when defined, the lowest-index active req
//   always wins and the round-robin pointer is held at 0.
//
// Ports:
//   clock     in   rising-edge system clock
//   reset     in   synchronous active-high reset
//   req       in   [NUM_REQ]       per-requester request level
//   clr_req   in   [NUM_REQ]       per-requester op (1 = clear, 0 = load)
//   req_data  in   [NUM_REQ*WIDTH] per-requester data, slice i at [i*WIDTH +: WIDTH]
//   sys_clear in   global clear, highest priority
//   reg_load  out  register load strobe
//   reg_clear out  register clear strobe
//   reg_data  out  [WIDTH] register data
//   gnt       out  [NUM_REQ] one-hot grant, high during WRITE
//   ack       out  [NUM_REQ] one-hot completion pulse, high during ACK
//   busy      out  high in every state except IDLE
module reg_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned PTR_W   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       clr_req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     sys_clear,
  output logic                     reg_load,
  output logic                     reg_clear,
  output logic [WIDTH-1:0]         reg_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ACK   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic               op_clr_q, op_clr_d;
  logic               sys_q, sys_d;
  logic [WIDTH-1:0]   data_q, data_d;

  logic               load_q, load_d;
  logic               clear_q, clear_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;

  logic               found;
  logic [PTR_W-1:0]   win_idx;
  int unsigned        cand;
  logic               sel_clr;
  logic [WIDTH-1:0]   sel_data;

  // Winner search starting at ptr_q and wrapping modulo NUM_REQ. In the
  // fixed-priority build ptr_q is pinned to 0, so the same search yields
  // the lowest active index.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && req[cand[PTR_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_clr  = 1'b0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        sel_clr  = clr_req[i];
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // State register (outputs registered alongside the FSM state)
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      op_clr_q <= 1'b0;
      sys_q    <= 1'b0;
      data_q   <= '0;
      load_q   <= 1'b0;
      clear_q  <= 1'b0;
      rdata_q  <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      op_clr_q <= op_clr_d;
      sys_q    <= sys_d;
      data_q   <= data_d;
      load_q   <= load_d;
      clear_q  <= clear_d;
      rdata_q  <= rdata_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and transaction latch
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    op_clr_d = op_clr_q;
    sys_d    = sys_q;
    data_d   = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (sys_clear) begin
          sys_d    = 1'b1;
          op_clr_d = 1'b1;
          win_d    = '0;
          data_d   = '0;
          state_d  = S_WRITE;
        end else if (found) begin
          sys_d    = 1'b0;
          op_clr_d = sel_clr;
          win_d    = win_idx;
          data_d   = sel_data;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
`ifdef REG_ARB_FIXED_PRIORITY_EN
        ptr_d = '0;
`else
        if (!sys_q) begin
          ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output comes out of a flop
  always_comb begin
    load_d  = 1'b0;
    clear_d = 1'b0;
    rdata_d = '0;
    gnt_d   = '0;
    ack_d   = '0;
    busy_d  = 1'b0;
    unique case (state_d)
      S_WRITE: begin
        busy_d = 1'b1;
        if (op_clr_d) begin
          clear_d = 1'b1;
        end else begin
          load_d  = 1'b1;
          rdata_d = data_d;
        end
        if (!sys_d) begin
          gnt_d = NUM_REQ'(1) << win_d;
        end
      end
      S_ACK: begin
        busy_d = 1'b1;
        if (!sys_d) begin
          ack_d = NUM_REQ'(1) << win_d;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign reg_load  = load_q;
  assign reg_clear = clear_q;
  assign reg_data  = rdata_q;
  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  clr;
  logic [19:0] data;
  logic        sys;
  logic        reg_load;
  logic        reg_clear;
  logic [4:0]  reg_data;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        busy;

  reg_write_arbiter #(
    .NUM_REQ(4),
    .WIDTH  (5),
    .PTR_W  (2)
  ) dut (
    .clock    (clk),
    .reset    (rst),
    .req      (req),
    .clr_req  (clr),
    .req_data (data),
    .sys_clear(sys),
    .reg_load (reg_load),
    .reg_clear(reg_clear),
    .reg_data (reg_data),
    .gnt      (gnt),
    .ack      (ack),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // exp packs {reg_load, reg_clear, reg_data, gnt, ack, busy}
  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  clr;
    logic [19:0] data;
    logic        sys;
    logic [15:0] exp;
  } vec_t;

  vec_t        vec [64];
  int unsigned nvec;
  int          passed;
  int          total;

  task automatic add_row(input logic r, input logic [3:0] rq, input logic [3:0] cl,
                         input logic [19:0] d, input logic s,
                         input logic ld, input logic cr, input logic [4:0] rd,
                         input logic [3:0] g, input logic [3:0] a, input logic b);
    vec[nvec].rst  = r;
    vec[nvec].req  = rq;
    vec[nvec].clr  = cl;
    vec[nvec].data = d;
    vec[nvec].sys  = s;
    vec[nvec].exp  = {ld, cr, rd, g, a, b};
    nvec++;
  endtask

  // One full transaction: WRITE row, ACK row, back-to-IDLE row.
  // w < 0 marks an ownerless sys_clear transaction.
  task automatic add_txn(input logic [3:0] rq, input logic [3:0] cl, input logic [19:0] d,
                         input logic s, input int w, input logic is_clr, input logic [4:0] rd);
    logic [3:0] oh;
    oh = (w < 0) ? 4'b0000 : 4'(1 << w);
    add_row(1'b0, rq, cl, d, s, !is_clr, is_clr, rd, oh, 4'b0000, 1'b1);
    add_row(1'b0, rq, cl, d, s, 1'b0, 1'b0, 5'd0, 4'b0000, oh, 1'b1);
    add_row(1'b0, rq, cl, d, s, 1'b0, 1'b0, 5'd0, 4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    int cycles;
    logic got;
    int w;

    passed = 0;
    total  = 0;
    nvec   = 0;
    rst    = 1'b1;
    req    = '0;
    clr    = '0;
    data   = '0;
    sys    = 1'b0;

    // Reset, then a single load from requester 0
    add_row(1'b1, 4'b0000, 4'b0000, 20'd0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0000, 4'b0000, 1'b0);
    add_txn(4'b0001, 4'b0000, 20'd3, 1'b0, 0, 1'b0, 5'd3);

    // All four requesting continuously, data i = 10+i
    add_row(1'b1, 4'b0000, 4'b0000, 20'd0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0000, 4'b0000, 1'b0);
    for (int t = 0; t < 5; t++) begin
`ifdef REG_ARB_FIXED_PRIORITY_EN
      w = 0;
`else
      w = t % 4;
`endif
      add_txn(4'b1111, 4'b0000, {5'd13, 5'd12, 5'd11, 5'd10}, 1'b0, w, 1'b0, 5'(10 + w));
    end

    // Clear op from requester 2: data must be forced to 0
    add_txn(4'b0100, 4'b0100, {5'd0, 5'd31, 10'd0}, 1'b0, 2, 1'b1, 5'd0);

    // sys_clear together with req[1]: ownerless clear first, then the load
    add_txn(4'b0010, 4'b0000, {10'd0, 5'd7, 5'd0}, 1'b1, -1, 1'b1, 5'd0);
    add_txn(4'b0010, 4'b0000, {10'd0, 5'd7, 5'd0}, 1'b0, 1, 1'b0, 5'd7);

    // Pointer skips past lower indices (rr), then wraps to 0
`ifdef REG_ARB_FIXED_PRIORITY_EN
    add_txn(4'b1011, 4'b0000, {5'd20, 5'd0, 5'd4, 5'd2}, 1'b0, 0, 1'b0, 5'd2);
`else
    add_txn(4'b1011, 4'b0000, {5'd20, 5'd0, 5'd4, 5'd2}, 1'b0, 3, 1'b0, 5'd20);
`endif
    add_txn(4'b1001, 4'b0000, {5'd20, 5'd0, 5'd4, 5'd2}, 1'b0, 0, 1'b0, 5'd2);

    // Reset during WRITE of requester 3: no ack, pointer back to 0
    add_row(1'b0, 4'b1000, 4'b0000, {5'd21, 15'd0}, 1'b0, 1'b1, 1'b0, 5'd21, 4'b1000, 4'b0000, 1'b1);
    add_row(1'b1, 4'b1000, 4'b0000, {5'd21, 15'd0}, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0000, 4'b0000, 1'b0);
    add_row(1'b0, 4'b0000, 4'b0000, 20'd0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0000, 4'b0000, 1'b0);
    add_row(1'b0, 4'b0000, 4'b0000, 20'd0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0000, 4'b0000, 1'b0);
    add_txn(4'b1001, 4'b0000, {5'd25, 10'd0, 5'd6}, 1'b0, 0, 1'b0, 5'd6);

    // req = 1010 held for three transactions
`ifdef REG_ARB_FIXED_PRIORITY_EN
    add_txn(4'b1010, 4'b0000, {5'd9, 5'd0, 5'd8, 5'd0}, 1'b0, 1, 1'b0, 5'd8);
    add_txn(4'b1010, 4'b0000, {5'd9, 5'd0, 5'd8, 5'd0}, 1'b0, 1, 1'b0, 5'd8);
    add_txn(4'b1010, 4'b0000, {5'd9, 5'd0, 5'd8, 5'd0}, 1'b0, 1, 1'b0, 5'd8);
`else
    add_txn(4'b1010, 4'b0000, {5'd9, 5'd0, 5'd8, 5'd0}, 1'b0, 1, 1'b0, 5'd8);
    add_txn(4'b1010, 4'b0000, {5'd9, 5'd0, 5'd8, 5'd0}, 1'b0, 3, 1'b0, 5'd9);
    add_txn(4'b1010, 4'b0000, {5'd9, 5'd0, 5'd8, 5'd0}, 1'b0, 1, 1'b0, 5'd8);
`endif
    add_row(1'b0, 4'b0000, 4'b0000, 20'd0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0000, 4'b0000, 1'b0);

    for (int unsigned i = 0; i < nvec; i++) begin
      @(negedge clk);
      rst  = vec[i].rst;
      req  = vec[i].req;
      clr  = vec[i].clr;
      data = vec[i].data;
      sys  = vec[i].sys;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d {load,clear,data,gnt,ack,busy}", i),
          32'({reg_load, reg_clear, reg_data, gnt, ack, busy}), 32'(vec[i].exp));
    end

    // Requester 2 pulses req for one cycle then scrambles its inputs:
    // the latched transaction must still complete with the original data.
    @(negedge clk);
    rst  = 1'b0;
    sys  = 1'b0;
    req  = 4'b0100;
    clr  = 4'b0000;
    data = {5'd0, 5'd17, 10'd0};
    @(posedge clk);
    #1;
    chk("hs_write {load,clear,data,gnt}", 32'({reg_load, reg_clear, reg_data, gnt}),
        32'({1'b1, 1'b0, 5'd17, 4'b0100}));
    @(negedge clk);
    req  = 4'b0000;
    clr  = 4'b1111;
    data = '1;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 4) begin
      @(posedge clk);
      #1;
      cycles++;
      if (ack != 4'b0000) got = 1'b1;
    end
    chk("hs_ack", 32'(ack), 32'(4'b0100));
    chk("hs_ack_latency", 32'(cycles), 32'd1);
    chk("hs_ack_strobes", 32'({reg_load, reg_clear, reg_data}), 32'd0);
    @(posedge clk);
    #1;
    chk("hs_idle_busy", 32'({busy, gnt, ack}), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
